rssb_seq_ctrl: RTL and testbench

Single-clock sequencer for the 1-bit RSSB core. It generates the three phase strobes that advance the memory stage (fetch), CPU execute stage and CPU writeback stage, so the core runs from one clock instead of three free-running ones. It also provides start/halt control, a memory wait-state handshake with timeout, and an executed-instruction counter. It sits beside the CPU/memory pair and drives their phase enables.

---
 rtl/rssb_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_rssb_seq_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rssb_seq_ctrl.sv
// rtl/rssb_seq_ctrl.sv - single-clock phase sequencer for the 1-bit RSSB core (optional step mode: RSSB_SEQ_STEP_EN)
module rssb_seq_ctrl #(
  parameter int CW   = 8,
  parameter int MAXI = 0,
  parameter int TW   = 4,
  parameter int TMO  = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          halt_req,
  input  logic          mem_ready,
`ifdef RSSB_SEQ_STEP_EN
  input  logic          step,
`endif
  output logic          ph0_en,
  output logic          ph1_en,
  output logic          ph2_en,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] icnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4,
    S_PAUSE = 3'd5
  } state_t;

  state_t        state;
  state_t        next;
  logic          halt_lat;
  logic [TW-1:0] wcnt;
  logic [CW-1:0] icnt_inc;
  logic          wait_max;
  logic          maxi_hit;
  logic          halt_now;
  logic          active;
  logic          restart;

  assign icnt_inc = icnt + CW'(1);
  assign wait_max = (wcnt == TW'(TMO));
  assign maxi_hit = (MAXI != 0) && (icnt_inc == CW'(MAXI));
  // A request arriving in the WB cycle itself still stops at this boundary.
  assign halt_now = halt_lat || halt_req || maxi_hit;
  assign active   = (state == S_FETCH) || (state == S_EXEC) || (state == S_WB) || (state == S_PAUSE);
  assign restart  = ((state == S_IDLE) || (state == S_HALT)) && start;

  // State register; reset drops straight to IDLE so no strobe survives it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next;
    end
  end

  // Next-state decode: one instruction is FETCH (+waits), EXEC, WB.
  always_comb begin
    next = state;
    case (state)
      S_IDLE, S_HALT: begin
        if (start) next = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ready)     next = S_EXEC;
        else if (wait_max) next = S_HALT;
      end
      S_EXEC: next = S_WB;
      S_WB: begin
        if (halt_now) next = S_HALT;
`ifdef RSSB_SEQ_STEP_EN
        else          next = S_PAUSE;
`else
        else          next = S_FETCH;
`endif
      end
`ifdef RSSB_SEQ_STEP_EN
      S_PAUSE: begin
        if (halt_req || halt_lat) next = S_HALT;
        else if (step)            next = S_FETCH;
      end
`endif
      default: next = S_IDLE;
    endcase
  end

  // Moore output decode: strobes depend on the state register only.
  always_comb begin
    ph0_en = (state == S_FETCH);
    ph1_en = (state == S_EXEC);
    ph2_en = (state == S_WB);
    busy   = active;
    done   = (state == S_HALT);
  end

  // Run bookkeeping: instruction count, fetch wait count, timeout flag, halt latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      icnt     <= '0;
      wcnt     <= '0;
      timeout  <= 1'b0;
      halt_lat <= 1'b0;
    end else begin
      if (restart) begin
        icnt     <= '0;
        wcnt     <= '0;
        timeout  <= 1'b0;
        halt_lat <= 1'b0;
      end else begin
        if (active && halt_req) halt_lat <= 1'b1;
        if (state == S_FETCH) begin
          if (mem_ready)     wcnt    <= '0;
          else if (wait_max) timeout <= 1'b1;
          else               wcnt    <= wcnt + TW'(1);
        end
        if (state == S_WB) icnt <= icnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_rssb_seq_ctrl.sv
// tb/tb_rssb_seq_ctrl.sv - randomized self-checking bench for rssb_seq_ctrl against a run-level model
module tb_rssb_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic halt_req = 1'b0;
  logic mem_ready = 1'b0;
`ifdef RSSB_SEQ_STEP_EN
  logic step = 1'b1;
`endif

  logic ph0_0, ph1_0, ph2_0, busy_0, done_0, tmo_0;
  logic [7:0] icnt_0;
  logic ph0_5, ph1_5, ph2_5, busy_5, done_5, tmo_5;
  logic [7:0] icnt_5;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  rssb_seq_ctrl #(.CW(8), .MAXI(0), .TW(4), .TMO(15)) dut0 (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .mem_ready(mem_ready),
`ifdef RSSB_SEQ_STEP_EN
    .step(step),
`endif
    .ph0_en(ph0_0), .ph1_en(ph1_0), .ph2_en(ph2_0), .busy(busy_0), .done(done_0),
    .timeout(tmo_0), .icnt(icnt_0)
  );

  rssb_seq_ctrl #(.CW(8), .MAXI(5), .TW(4), .TMO(15)) dut5 (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .mem_ready(mem_ready),
`ifdef RSSB_SEQ_STEP_EN
    .step(step),
`endif
    .ph0_en(ph0_5), .ph1_en(ph1_5), .ph2_en(ph2_5), .busy(busy_5), .done(done_5),
    .timeout(tmo_5), .icnt(icnt_5)
  );

  // Run-level model: phase 0 idle, 1 fetch, 2 execute, 3 writeback, 4 halted.
  typedef struct {
    int phase;
    int count;
    int waited;
    bit timed_out;
    bit stop_pending;
  } run_t;

  run_t m0, m5;

  function automatic run_t run_clear();
    run_t r;
    r.phase = 0; r.count = 0; r.waited = 0; r.timed_out = 1'b0; r.stop_pending = 1'b0;
    return r;
  endfunction

  function automatic run_t run_advance(run_t r, int limit, bit go, bit stop, bit rdy);
    run_t n = r;
    if (r.phase >= 1 && r.phase <= 3 && stop) n.stop_pending = 1'b1;
    if (r.phase == 0 || r.phase == 4) begin
      if (go) begin
        n = run_clear();
        n.phase = 1;
      end
    end else if (r.phase == 1) begin
      if (rdy) begin
        n.phase = 2; n.waited = 0;
      end else if (r.waited >= 15) begin
        n.phase = 4; n.timed_out = 1'b1;
      end else begin
        n.waited = r.waited + 1;
      end
    end else if (r.phase == 2) begin
      n.phase = 3;
    end else begin
      n.count = (r.count + 1) % 256;
      if (n.stop_pending || (limit != 0 && n.count == limit)) n.phase = 4;
      else n.phase = 1;
    end
    return n;
  endfunction

  function automatic logic [13:0] run_outs(run_t r);
    logic [7:0] c;
    c = r.count[7:0];
    return {r.phase == 1, r.phase == 2, r.phase == 3, (r.phase >= 1 && r.phase <= 3),
            r.phase == 4, r.timed_out, c};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance both models on every clock edge; reset wins asynchronously.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m0 = run_clear();
      m5 = run_clear();
    end else begin
      m0 = run_advance(m0, 0, start, halt_req, mem_ready);
      m5 = run_advance(m5, 5, start, halt_req, mem_ready);
    end
  end

  // Every cycle out of reset, both instances must match their model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("outs_maxi0", {ph0_0, ph1_0, ph2_0, busy_0, done_0, tmo_0, icnt_0}, run_outs(m0));
      chk("outs_maxi5", {ph0_5, ph1_5, ph2_5, busy_5, done_5, tmo_5, icnt_5}, run_outs(m5));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int n, cnt, run, maxrun, fetchn, t2, t3, waits, mode;
  bit prev0;

  initial begin
    cyc(); cyc(); cyc();
    chk("reset_outs", {ph0_0, ph1_0, ph2_0, busy_0, done_0, tmo_0, icnt_0,
                       ph0_5, ph1_5, ph2_5, busy_5, done_5, tmo_5, icnt_5}, 0);
    rst = 1'b0;
    cyc();

    // Free run, zero wait states, limit of five.
    mem_ready = 1'b1;
    start = 1'b1; cyc(); start = 1'b0;
    n = 1;
    while (!done_5 && n < 100) begin cyc(); n++; end
    chk("free_run_done_latency", n, 16);
    chk("free_run_icnt", icnt_5, 5);

    // Three wait states on the second fetch.
    start = 1'b1; cyc(); start = 1'b0;
    fetchn = 0; run = 0; maxrun = 0; prev0 = 1'b0; t2 = -1; t3 = -1; waits = 0;
    for (int c = 0; c < 40; c++) begin
      if (ph0_5 && !prev0) begin
        fetchn++;
        if (fetchn == 2) t2 = c;
        if (fetchn == 3) t3 = c;
      end
      run = ph0_5 ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
      prev0 = ph0_5;
      if (ph0_5 && fetchn == 2 && waits < 3) begin
        mem_ready = 1'b0; waits++;
      end else begin
        mem_ready = 1'b1;
      end
      cyc();
    end
    chk("wait_ph0_run", maxrun, 4);
    chk("wait_instr_len", t3 - t2, 6);
    chk("wait_icnt", icnt_5, 5);

    // Fetch timeout.
    mem_ready = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    n = 0; cnt = 0;
    while (!done_5 && n < 100) begin
      if (ph0_5) cnt++;
      cyc(); n++;
    end
    chk("timeout_fetch_cycles", cnt, 16);
    chk("timeout_flag", tmo_5, 1);
    chk("timeout_icnt", icnt_5, 0);
    mem_ready = 1'b1;
    start = 1'b1; cyc(); start = 1'b0;
    chk("timeout_cleared", tmo_5, 0);

    // Halt at instruction boundary; a request while idle is ignored.
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    halt_req = 1'b1; cyc(); cyc(); halt_req = 1'b0; cyc();
    chk("idle_halt_ignored", {busy_0, done_0}, 0);
    start = 1'b1; cyc(); start = 1'b0;
    n = 0; cnt = 0;
    while (!done_0 && n < 100) begin
      if (ph1_0) cnt++;
      halt_req = (ph1_0 && cnt == 3);
      cyc(); n++;
    end
    halt_req = 1'b0;
    chk("halt_icnt", icnt_0, 3);
    chk("halt_icnt_maxi5", icnt_5, 3);

    // Asynchronous reset in the middle of EXEC.
    start = 1'b1; cyc(); start = 1'b0;
    n = 0;
    while (!ph1_0 && n < 50) begin cyc(); n++; end
    chk("reach_exec", ph1_0, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outs", {ph0_0, ph1_0, ph2_0, busy_0, done_0, tmo_0, icnt_0,
                           ph0_5, ph1_5, ph2_5, busy_5, done_5, tmo_5, icnt_5}, 0);
    cyc(); rst = 1'b0;
    cyc(); cyc(); cyc();
    chk("post_rst_idle", {busy_0, done_0, busy_5, done_5}, 0);

    // Counter wrap with unlimited instruction count.
    start = 1'b1; cyc(); start = 1'b0;
    cnt = 0; n = 0;
    while (cnt < 258 && n < 2000) begin
      cyc(); n++;
      if (ph2_0) cnt++;
    end
    chk("wrap_wb_count", cnt, 258);
    cyc();
    chk("wrap_icnt", icnt_0, 2);

    // Randomized traffic in several memory-readiness regimes.
    mode = 0;
    for (int k = 0; k < 3000; k++) begin
      if (k % 250 == 0) mode = $urandom_range(0, 2);
      start    = ($urandom_range(0, 23) == 0);
      halt_req = ($urandom_range(0, 47) == 0);
      case (mode)
        0:       mem_ready = ($urandom_range(0, 9) != 0);
        1:       mem_ready = ($urandom_range(0, 9) < 3);
        default: mem_ready = ($urandom_range(0, 40) == 0);
      endcase
      cyc();
    end
    start = 1'b0; halt_req = 1'b0;
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
